// File: rtl/multi_note_pkg.sv
// Shared types for the note sequencer: FSM state, length codes and the queued command word.
package multi_note_pkg;

   typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

   localparam logic [1:0] LEN_1X = 2'd0;
   localparam logic [1:0] LEN_2X = 2'd1;
   localparam logic [1:0] LEN_4X = 2'd2;
   localparam logic [1:0] LEN_8X = 2'd3;

   // Widest note index a command can carry; the top zero-extends its NOTE_W field into this.
   localparam int CMD_NUM_W = 8;

   typedef struct packed {
      logic [CMD_NUM_W-1:0] num;
      logic [1:0]           len;
   } cmd_t;

endpackage

// File: rtl/multi_note_sequencer_if.sv
// Note command channel between the switch/button front end and the sequencer.
interface multi_note_sequencer_if #(
   parameter int NOTE_W = 3
);
   // A command transfers on every clock edge where play_note_val and play_note_rdy are both
   // high; num/len must be stable while val is high, and rdy never depends on val.
   logic              play_note_val;
   logic              play_note_rdy;
   logic [NOTE_W-1:0] play_note_num;
   logic [1:0]        play_note_len;

   modport master (output play_note_val, output play_note_num, output play_note_len,
                   input  play_note_rdy);
   modport slave  (input  play_note_val, input  play_note_num, input  play_note_len,
                   output play_note_rdy);
endinterface

// File: rtl/note_cmd_fifo.sv
// Synchronous FIFO for note commands with occupancy count and a synchronous clear.
module note_cmd_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full && !clear;
   assign pop_ok  = pop && !empty && !clear;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/multi_note_sequencer.sv
// Queued square-wave note player: buffers note commands and plays them back to back,
// each for note_duration << len cycles.
module multi_note_sequencer
   import multi_note_pkg::*;
#(
   parameter int NUM_NOTES = 7,
   parameter int PERIOD_W  = 8,
   parameter int DUR_W     = 16,
   parameter int DEPTH     = 4,
   localparam int NOTE_W   = $clog2(NUM_NOTES + 1),
   localparam int CNT_W    = $clog2(DEPTH) + 1,
   localparam int DCW      = DUR_W + 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DUR_W-1:0]              note_duration,
   input  logic [NUM_NOTES*PERIOD_W-1:0] note_periods,
   input  logic                          flush,
   multi_note_sequencer_if.slave         cmd_if,
   output logic [NOTE_W-1:0]             note_sel,
   output logic                          note,
   output logic                          busy,
   output logic [CNT_W-1:0]              queue_count,
   output state_t                        fsm_state
);

   state_t              state;
   cmd_t                wr_cmd;
   cmd_t                rd_cmd;
   logic                fifo_full;
   logic                fifo_empty;
   logic                push;
   logic                pop;
   logic [DCW-1:0]      dur_cnt;
   logic [PERIOD_W-1:0] hp_cnt;
   logic [PERIOD_W-1:0] period;

   logic [PERIOD_W-1:0] period_tbl [2**NOTE_W];
   logic                in_range;
   logic [NOTE_W-1:0]   load_sel;
   logic [PERIOD_W-1:0] load_period;
   logic [DCW-1:0]      dur_base;
   logic [DCW-1:0]      dur_load;

   assign wr_cmd                = '{num: CMD_NUM_W'(cmd_if.play_note_num), len: cmd_if.play_note_len};
   assign cmd_if.play_note_rdy  = !fifo_full && !flush;
   assign push                  = cmd_if.play_note_val && cmd_if.play_note_rdy;
   assign pop                   = !flush && !fifo_empty &&
                                  ((state == IDLE) || (dur_cnt == '0));
   assign fsm_state             = state;

   note_cmd_fifo #(
      .WIDTH ($bits(cmd_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear   (flush),
      .push    (push),
      .wr_data (wr_cmd),
      .pop     (pop),
      .rd_data (rd_cmd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (queue_count)
   );

   // Index 0 (rest) and any unused index above NUM_NOTES read as a silent period.
   for (genvar k = 0; k < 2**NOTE_W; k++) begin : g_period_tbl
      if (k >= 1 && k <= NUM_NOTES) begin : g_note
         assign period_tbl[k] = note_periods[(k-1)*PERIOD_W +: PERIOD_W];
      end else begin : g_rest
         assign period_tbl[k] = '0;
      end
   end

   assign in_range    = (rd_cmd.num <= CMD_NUM_W'(NUM_NOTES));
   assign load_sel    = in_range ? rd_cmd.num[NOTE_W-1:0] : '0;
   assign load_period = in_range ? period_tbl[rd_cmd.num[NOTE_W-1:0]] : '0;
   assign dur_base    = (note_duration == '0) ? DCW'(1) : DCW'(note_duration);
   assign dur_load    = (dur_base << rd_cmd.len) - DCW'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         note_sel <= '0;
         note     <= 1'b0;
         busy     <= 1'b0;
         dur_cnt  <= '0;
         hp_cnt   <= '0;
         period   <= '0;
      end else if (flush) begin
         state    <= IDLE;
         note_sel <= '0;
         note     <= 1'b0;
         busy     <= 1'b0;
         dur_cnt  <= '0;
         hp_cnt   <= '0;
      end else if (pop) begin
         // Covers both the IDLE start and the gapless hand-off at the end of a note.
         state    <= PLAY;
         busy     <= 1'b1;
         note_sel <= load_sel;
         note     <= 1'b0;
         dur_cnt  <= dur_load;
         hp_cnt   <= load_period;
         period   <= load_period;
      end else begin
         case (state)
            PLAY: begin
               if (dur_cnt == '0) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  note_sel <= '0;
                  note     <= 1'b0;
               end else begin
                  dur_cnt <= dur_cnt - DCW'(1);
                  if (period != '0) begin
                     if (hp_cnt == '0) begin
                        note   <= ~note;
                        hp_cnt <= period;
                     end else begin
                        hp_cnt <= hp_cnt - PERIOD_W'(1);
                     end
                  end
               end
            end
            default: begin
               note_sel <= '0;
               note     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multi_note_sequencer.sv
// Directed bench for multi_note_sequencer; NUM_NOTES=6 so note number 7 is out of range.
module tb_multi_note_sequencer;
   import multi_note_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] note_duration;
   logic [47:0] note_periods;
   logic        flush;
   logic [2:0]  note_sel;
   logic        note;
   logic        busy;
   logic [2:0]  queue_count;
   state_t      fsm_state;
   int          total = 0;
   int          bad = 0;

   multi_note_sequencer_if #(.NOTE_W(3)) cmd_if ();

   multi_note_sequencer #(
      .NUM_NOTES (6),
      .PERIOD_W  (8),
      .DUR_W     (16),
      .DEPTH     (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .note_duration (note_duration),
      .note_periods  (note_periods),
      .flush         (flush),
      .cmd_if        (cmd_if),
      .note_sel      (note_sel),
      .note          (note),
      .busy          (busy),
      .queue_count   (queue_count),
      .fsm_state     (fsm_state)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] n, input logic [1:0] l);
      int w;
      cmd_if.play_note_val = 1'b1;
      cmd_if.play_note_num = n;
      cmd_if.play_note_len = l;
      w = 0;
      while (!cmd_if.play_note_rdy && w < 400) begin
         tick();
         w++;
      end
      total++;
      if (w >= 400) begin bad++; $display("FAIL push_rdy_timeout: got %0d cycles want <400", w); end
      @(posedge clk);
      #1;
      cmd_if.play_note_val = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      flush = 1'b0;
      cmd_if.play_note_val = 1'b0;
      cmd_if.play_note_num = '0;
      cmd_if.play_note_len = '0;
      note_duration = 16'd10;
      // note1=3 note2=2 note3=1 note4=0 note5=4 note6=5
      note_periods = {8'd5, 8'd4, 8'd0, 8'd1, 8'd2, 8'd3};
      repeat (2) tick();
      total++; if (note_sel !== 3'd0) begin bad++; $display("FAIL rst_sel: got %0d want 0", note_sel); end
      total++; if (note !== 1'b0) begin bad++; $display("FAIL rst_note: got %0d want 0", note); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0d want 0", busy); end
      total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", queue_count); end
      total++; if (cmd_if.play_note_rdy !== 1'b1) begin bad++; $display("FAIL rst_rdy: got %0d want 1", cmd_if.play_note_rdy); end
      total++; if (fsm_state !== IDLE) begin bad++; $display("FAIL rst_state: got %0d want 0", fsm_state); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single_note();
      logic [9:0] pat;
      pat = 10'b0011110000;
      note_duration = 16'd10;
      push(3'd1, LEN_1X);
      total++; if (queue_count !== 3'd1) begin bad++; $display("FAIL t1_count: got %0d want 1", queue_count); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy_pre: got %0d want 0", busy); end
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0) note_duration = 16'd3;  // must not shorten the note already loaded
         total++; if (note_sel !== 3'd1) begin bad++; $display("FAIL t1_sel[%0d]: got %0d want 1", i, note_sel); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy[%0d]: got %0d want 1", i, busy); end
         total++; if (note !== pat[i]) begin bad++; $display("FAIL t1_note[%0d]: got %0d want %0d", i, note, pat[i]); end
      end
      tick();
      total++; if (note_sel !== 3'd0) begin bad++; $display("FAIL t1_sel_end: got %0d want 0", note_sel); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy_end: got %0d want 0", busy); end
      total++; if (note !== 1'b0) begin bad++; $display("FAIL t1_note_end: got %0d want 0", note); end
      total++; if (fsm_state !== IDLE) begin bad++; $display("FAIL t1_state_end: got %0d want 0", fsm_state); end
   endtask

   task automatic test_back_to_back();
      logic [9:0] pat;
      pat = 10'b1000111000;
      note_duration = 16'd5;
      push(3'd2, LEN_2X);
      push(3'd0, LEN_1X);
      total++; if (queue_count !== 3'd1) begin bad++; $display("FAIL t2_count: got %0d want 1", queue_count); end
      for (int i = 0; i < 10; i++) begin
         if (i > 0) tick();
         total++; if (note_sel !== 3'd2) begin bad++; $display("FAIL t2_sel[%0d]: got %0d want 2", i, note_sel); end
         total++; if (note !== pat[i]) begin bad++; $display("FAIL t2_note[%0d]: got %0d want %0d", i, note, pat[i]); end
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (note_sel !== 3'd0) begin bad++; $display("FAIL t2_rest_sel[%0d]: got %0d want 0", i, note_sel); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL t2_rest_busy[%0d]: got %0d want 1", i, busy); end
         total++; if (note !== 1'b0) begin bad++; $display("FAIL t2_rest_note[%0d]: got %0d want 0", i, note); end
      end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t2_busy_end: got %0d want 0", busy); end
   endtask

   task automatic test_full_queue();
      logic [2:0] order [4];
      int w;
      int gap;
      order[0] = 3'd3; order[1] = 3'd5; order[2] = 3'd6; order[3] = 3'd1;
      note_duration = 16'd20;
      push(3'd1, LEN_8X);
      push(3'd2, LEN_1X);
      push(3'd3, LEN_1X);
      push(3'd5, LEN_1X);
      push(3'd6, LEN_1X);
      total++; if (queue_count !== 3'd4) begin bad++; $display("FAIL t3_count_full: got %0d want 4", queue_count); end
      total++; if (cmd_if.play_note_rdy !== 1'b0) begin bad++; $display("FAIL t3_rdy_full: got %0d want 0", cmd_if.play_note_rdy); end
      cmd_if.play_note_val = 1'b1;
      cmd_if.play_note_num = 3'd1;
      cmd_if.play_note_len = LEN_1X;
      w = 0;
      while (!cmd_if.play_note_rdy && w < 400) begin
         tick();
         w++;
      end
      // 160-cycle note loaded one edge after its push ends 157 edges after the last push
      total++; if (w != 157) begin bad++; $display("FAIL t3_hold_cycles: got %0d want 157", w); end
      @(posedge clk);
      #1;
      cmd_if.play_note_val = 1'b0;
      total++; if (queue_count !== 3'd4) begin bad++; $display("FAIL t3_count_refill: got %0d want 4", queue_count); end
      total++; if (note_sel !== 3'd2) begin bad++; $display("FAIL t3_sel_first: got %0d want 2", note_sel); end
      gap = 19;
      for (int k = 0; k < 4; k++) begin
         repeat (gap) tick();
         gap = 20;
         total++; if (note_sel !== order[k]) begin bad++; $display("FAIL t3_order[%0d]: got %0d want %0d", k, note_sel, order[k]); end
         total++; if (queue_count !== 3'(3 - k)) begin bad++; $display("FAIL t3_drain_count[%0d]: got %0d want %0d", k, queue_count, 3 - k); end
      end
      repeat (20) tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t3_busy_end: got %0d want 0", busy); end
   endtask

   task automatic test_flush();
      note_duration = 16'd50;
      push(3'd3, LEN_1X);
      push(3'd5, LEN_1X);
      push(3'd6, LEN_1X);
      total++; if (queue_count !== 3'd2) begin bad++; $display("FAIL t4_count_pre: got %0d want 2", queue_count); end
      total++; if (note_sel !== 3'd3) begin bad++; $display("FAIL t4_sel_pre: got %0d want 3", note_sel); end
      flush = 1'b1;
      cmd_if.play_note_val = 1'b1;
      cmd_if.play_note_num = 3'd1;
      #1;
      total++; if (cmd_if.play_note_rdy !== 1'b0) begin bad++; $display("FAIL t4_rdy_flush: got %0d want 0", cmd_if.play_note_rdy); end
      @(posedge clk);
      #1;
      flush = 1'b0;
      cmd_if.play_note_val = 1'b0;
      total++; if (note_sel !== 3'd0) begin bad++; $display("FAIL t4_sel: got %0d want 0", note_sel); end
      total++; if (note !== 1'b0) begin bad++; $display("FAIL t4_note: got %0d want 0", note); end
      total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL t4_count: got %0d want 0", queue_count); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_busy: got %0d want 0", busy); end
      repeat (3) tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_busy_after: got %0d want 0", busy); end
      total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL t4_count_after: got %0d want 0", queue_count); end
   endtask

   task automatic test_async_reset();
      note_duration = 16'd10;
      push(3'd1, LEN_1X);
      push(3'd2, LEN_1X);
      repeat (4) tick();
      total++; if (note !== 1'b1) begin bad++; $display("FAIL t5_note_pre: got %0d want 1", note); end
      #2;
      rst = 1'b0;
      #1;
      total++; if (note_sel !== 3'd0) begin bad++; $display("FAIL t5_sel: got %0d want 0", note_sel); end
      total++; if (note !== 1'b0) begin bad++; $display("FAIL t5_note: got %0d want 0", note); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_busy: got %0d want 0", busy); end
      total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL t5_count: got %0d want 0", queue_count); end
      total++; if (cmd_if.play_note_rdy !== 1'b1) begin bad++; $display("FAIL t5_rdy: got %0d want 1", cmd_if.play_note_rdy); end
      @(negedge clk);
      rst = 1'b1;
      tick();
      push(3'd5, LEN_1X);
      tick();
      total++; if (note_sel !== 3'd5) begin bad++; $display("FAIL t5_sel_after: got %0d want 5", note_sel); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL t5_busy_after: got %0d want 1", busy); end
      repeat (10) tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_busy_end: got %0d want 0", busy); end
   endtask

   task automatic test_edge_values();
      logic [7:0] pat;
      pat = 8'b11110000;
      note_duration = 16'd0;
      push(3'd1, LEN_8X);
      for (int i = 0; i < 8; i++) begin
         tick();
         total++; if (note_sel !== 3'd1) begin bad++; $display("FAIL t6_sel[%0d]: got %0d want 1", i, note_sel); end
         total++; if (note !== pat[i]) begin bad++; $display("FAIL t6_note[%0d]: got %0d want %0d", i, note, pat[i]); end
      end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t6_busy_end: got %0d want 0", busy); end
      note_duration = 16'd4;
      push(3'd7, LEN_1X);
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (note_sel !== 3'd0) begin bad++; $display("FAIL t6_oor_sel[%0d]: got %0d want 0", i, note_sel); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL t6_oor_busy[%0d]: got %0d want 1", i, busy); end
         total++; if (note !== 1'b0) begin bad++; $display("FAIL t6_oor_note[%0d]: got %0d want 0", i, note); end
      end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t6_oor_end: got %0d want 0", busy); end
      push(3'd4, LEN_1X);
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (note_sel !== 3'd4) begin bad++; $display("FAIL t6_p0_sel[%0d]: got %0d want 4", i, note_sel); end
         total++; if (note !== 1'b0) begin bad++; $display("FAIL t6_p0_note[%0d]: got %0d want 0", i, note); end
      end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t6_p0_end: got %0d want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_single_note();
      test_back_to_back();
      test_full_queue();
      test_flush();
      test_async_reset();
      test_edge_values();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_note_sequencer.md
# multi_note_sequencer

Parametrised successor to the single-command multi-note player. It accepts note commands through a val/rdy interface and buffers them in a DEPTH-entry queue. Each queued note is played back to back as a square wave, and each command carries its own length multiplier. The block sits between the switch/button front end and the audio pin. It exposes `note_sel` and a queue occupancy count for the seven-segment displays.

## Interface
- `NUM_NOTES`, default 7: number of selectable notes; note number 0 is always a rest.
- `PERIOD_W`, default 8: width of each note's half-period value.
- `DUR_W`, default 16: width of the base note duration.
- `DEPTH`, default 4: command queue depth; must be a power of 2 and ≥2.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous and active-low.
- `note_duration` in DUR_W: base note length in cycles; 0 is treated as 1.
- `note_periods` in NUM_NOTES*PERIOD_W: flat vector; slice k-1 holds the half-period value for note k.
- `flush` in 1: synchronous clear of the queue and the player.
- `play_note_val` in 1: command valid.
- `play_note_rdy` out 1: command ready.
- `play_note_num` in NOTE_W: note number; NOTE_W = $clog2(NUM_NOTES+1).
- `play_note_len` in 2: length code; the note lasts note_duration << len cycles (1×, 2×, 4×, 8×).
- `note_sel` out NOTE_W: note currently playing; 0 means idle or rest.
- `note` out 1: square-wave output.
- `busy` out 1: high while in the PLAY state.
- `queue_count` out $clog2(DEPTH)+1: number of queued commands, excluding the note currently playing.

## Operation
- **Reset values:** all outputs are 0 except `play_note_rdy`, which is 1. State is IDLE and the queue is empty.
- **Reset mid-note:** asserting `rst` during a note clears everything immediately; there is no deferred completion.
- **Handshake and push:**
  - A push occurs on any edge where `play_note_val` and `play_note_rdy` are both high.
  - `play_note_rdy` = !full && !flush. There is no bypass when full, even if a pop occurs in the same cycle.
- **FSM: IDLE**
  - If the queue is non-empty: pop, load `note_sel`, load the duration counter with (note_duration<<len)-1, and load the half-period counter. Set `note`=0, go to PLAY.
  - Otherwise hold `note_sel`=0 and `note`=0.
- **FSM: PLAY**
  - The half-period counter counts down from P, where P is the selected note's period slice. On reaching 0, `note` toggles and the counter reloads P. The full wave period is therefore 2*(P+1) cycles.
  - A rest (note 0), a note number > NUM_NOTES, or P==0 holds `note`=0 for the full duration. `note_sel` still shows the commanded number, or 0 if out of range.
  - The duration counter decrements each cycle. When it reaches 0 and the queue is non-empty, the next command is popped on the same edge, with no gap cycle.
  - When it reaches 0 and the queue is empty, go to IDLE.
- **Width rule:** the duration counter is DUR_W+3 bits, so 8× never overflows.
- **Parameter sampling:** `note_duration` and `note_periods` are sampled only at load. Changing them mid-note does not affect the current note.
- **Flush:**
  - The next edge empties the queue, enters IDLE, and drives `note_sel`=0 and `note`=0.
  - Flush wins over a simultaneous push (rdy is already low) and over a simultaneous pop.
- **Simultaneous push and pop on a non-full queue:** both occur and `queue_count` is unchanged.

## Timing
- A command pushed at edge t into an empty queue with the player IDLE is popped at edge t+1. `note_sel` and `busy` are valid from edge t+1.
- The note occupies exactly note_duration<<len cycles.
- The first rising edge of `note` comes P+1 cycles after load.
- `queue_count` updates at the edge of the push or pop.
- `play_note_rdy` is combinational from full and flush only; it does not depend on `play_note_val`.
- Back-to-back notes: `note_sel` changes on the same edge the previous duration ends.

## Structure
- **Package `multi_note_pkg`:**
  - state enum {IDLE, PLAY};
  - length-code constants LEN_1X..LEN_8X;
  - packed command struct {num, len}.
- **Sub-module `note_cmd_fifo`:** a parametrised synchronous FIFO with parameters (WIDTH, DEPTH), full/empty/count outputs, and a sync clear.
- **Top level:** the FSM, the duration counter, the half-period counter, and the period mux.

## Test plan
1. **Single note.** Params NUM_NOTES=7, DEPTH=4. Set note_duration=10, note1=3, then push {num=1,len=0}. Expect `note_sel`=1 for exactly 10 cycles starting 1 cycle after the push. `note` reads 0,0,0,0,1,1,1,1,0,0. Then IDLE with `note`=0.
2. **Back-to-back with rest.** Push {2,1} then {0,0}, with note_duration=5. Expect `note_sel`=2 for 10 cycles, then 0 for 5 cycles with `busy`=1 and `note`=0, then `busy`=0. There is no gap cycle between the two notes.
3. **Full queue.** While a long note plays, push 4 commands. Expect `queue_count`=4 and `play_note_rdy`=0. A fifth push is held until the next pop, then accepted, and the queue drains in FIFO order.
4. **Flush mid-note.** With 2 queued commands, assert `flush` for 1 cycle. Next edge: `note_sel`=0, `note`=0, `queue_count`=0, `busy`=0. A push coincident with the flush is not accepted.
5. **Async reset mid-note.** Drop `rst` between clock edges during PLAY. Outputs go to their reset values immediately. After release, a new push plays normally.
6. **Edge values.** Set note_duration=0 and push len=3: the note lasts 8 cycles. A note number greater than NUM_NOTES is played as a rest for the full duration with `note_sel`=0.
